intersection_scheduler: RTL
===========================

Name: intersection_scheduler

Overview:
Two-approach intersection controller that sequences a main-road light head and a side-road light head, with an optional pedestrian walk phase. Main road rests on green. The side road and pedestrians are served on demand via a car sensor and a latched push-button request. The block sits above the per-head light outputs and owns all phase timing, including the all-red clearance intervals.

Parameters:
CNT_W, 8, phase counter width; every T_* must be at least 1 and less than 2**CNT_W
T_MIN_GREEN, 8, minimum green duration in cycles for either road
T_MAX_SIDE, 20, maximum side-road green in cycles; must be at least T_MIN_GREEN
T_YELLOW, 3, yellow duration in cycles
T_ALL_RED, 2, all-red clearance duration in cycles
T_WALK, 6, pedestrian walk duration in cycles, both heads red

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
side_car  in  1  side-road vehicle present (level, synchronous to clk)
ped_req  in  1  pedestrian button (level or pulse, synchronous)
main_lights  out  3  {Red,Yellow,Green}, one-hot
side_lights  out  3  {Red,Yellow,Green}, one-hot
walk  out  1  pedestrian walk lamp
ped_ack  out  1  pedestrian request latched / waiting

Behaviour:
- Reset (reset_n=0, asynchronous): state=MAIN_GREEN, count=0, ped_pending=0.
  - Outputs during and after reset: main_lights=001, side_lights=100, walk=0, ped_ack=0.
- Outputs are Moore-decoded from state (combinational); ped_ack=ped_pending (registered).
- count clears to 0 on every state change; otherwise it increments each cycle and saturates at all-ones.
- "Phase length N" means the state is held for exactly N cycles when exit is unconditional.
- States and per-state outputs (main/side/walk), with transitions:
  - MAIN_GREEN (001/100/0): exit to MAIN_YELLOW when count>=T_MIN_GREEN-1 and (side_car or ped_pending). Otherwise hold indefinitely.
  - MAIN_YELLOW (010/100/0): exit after T_YELLOW cycles to ALL_RED_A.
  - ALL_RED_A (100/100/0): exit after T_ALL_RED cycles. Go to PED_WALK if ped_pending, else SIDE_GREEN.
  - PED_WALK (100/100/1): exit after T_WALK cycles. Go to SIDE_GREEN if side_car is high in the last cycle, else ALL_RED_B.
  - SIDE_GREEN (100/001/0): exit to SIDE_YELLOW when count==T_MAX_SIDE-1, or when count>=T_MIN_GREEN-1 and side_car=0.
  - SIDE_YELLOW (100/010/0): exit after T_YELLOW cycles to ALL_RED_B.
  - ALL_RED_B (100/100/0): exit after T_ALL_RED cycles to MAIN_GREEN.
  - Any unencoded state: next state MAIN_GREEN; outputs both heads red, walk=0.
- ped_pending:
  - Set on any cycle with ped_req=1, except while in PED_WALK (requests there are ignored).
  - Cleared on the exit cycle of PED_WALK.
  - Set and clear never coincide because requests are ignored in PED_WALK.
- Safety invariant, every cycle: main_lights and side_lights are never both non-red, and walk=1 only when both heads are red.
- A car that arrives during SIDE_YELLOW or ALL_RED_B is served on the next cycle round; it does not abort the clearance phases.
- Reset mid-phase immediately forces the reset state; no yellow or all-red phase is inserted.

Decomposition:
- Shared package traffic_pkg:
  - state enum with 3-bit encoding;
  - light constants RED=3'b100, YEL=3'b010, GRN=3'b001.
- One sub-module: phase_timer.
  - Function: CNT_W counter with synchronous clear and saturation.
  - Outputs: count, plus a compare output at_least(N).
  - Instantiated once; the FSM drives its clear.

Test Plan:
1. No inputs for 200 cycles after reset release -> main=001, side=100, walk=0 throughout; ped_ack=0.
2. side_car held high from cycle 2 -> MAIN_GREEN lasts 8 cycles, MAIN_YELLOW 3, ALL_RED_A 2, SIDE_GREEN 20 (capped at max), SIDE_YELLOW 3, ALL_RED_B 2, then MAIN_GREEN. Check exact edge counts.
3. side_car single-cycle pulse at cycle 15 -> MAIN_YELLOW from cycle 16. SIDE_GREEN lasts exactly 8 cycles (car absent), then yellow/all-red and back to main.
4. ped_req single-cycle pulse at cycle 3, no car -> ped_ack=1 from cycle 4. MAIN_GREEN ends at 8 cycles, then yellow 3, all-red 2, walk=1 for 6 cycles with both heads 100, then ALL_RED_B 2, MAIN_GREEN; ped_ack=0 after walk. A ped_req pulse during walk does not re-latch.
5. ped_req and side_car both high at cycle 0 and held -> PED_WALK 6 cycles, then SIDE_GREEN directly (no ALL_RED_B), 20 cycles.
6. reset_n low for 1 cycle mid-SIDE_GREEN (cycle 5 of phase) -> asynchronously main=001, side=100, walk=0, ped_ack=0. Sequence resumes per scenario 1/2 rules. Safety invariant is asserted on every cycle of every test.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state encoding and light-head constants for the intersection scheduler
package traffic_pkg;
    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_A   = 3'd2,
        PED_WALK    = 3'd3,
        SIDE_GREEN  = 3'd4,
        SIDE_YELLOW = 3'd5,
        ALL_RED_B   = 3'd6
    } state_t;
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
endpackage

// File: rtl/phase_timer.sv
// phase_timer: saturating phase counter with synchronous clear and a threshold compare
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] n,
    output logic [CNT_W-1:0] count,
    output logic             at_least
);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) count <= '0;
        else          count <= clr ? '0 : (&count ? count : count + 1'b1);
    assign at_least = count >= n;
endmodule

// File: rtl/intersection_scheduler.sv
// intersection_scheduler: main/side light sequencer with on-demand side and pedestrian phases
module intersection_scheduler
    import traffic_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int T_MIN_GREEN = 8,
    parameter int T_MAX_SIDE  = 20,
    parameter int T_YELLOW    = 3,
    parameter int T_ALL_RED   = 2,
    parameter int T_WALK      = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       side_car,
    input  logic       ped_req,
    output logic [2:0] main_lights,
    output logic [2:0] side_lights,
    output logic       walk,
    output logic       ped_ack
);
    state_t           state, state_nxt;
    logic [CNT_W-1:0] count, thresh;
    logic             at_least, ped_pending;
    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (state_nxt != state),
        .n        (thresh),
        .count    (count),
        .at_least (at_least)
    );
    always_comb begin
        state_nxt   = state;
        thresh      = '0;
        main_lights = RED;
        side_lights = RED;
        walk        = 1'b0;
        case (state)
            MAIN_GREEN: begin
                main_lights = GRN;
                thresh      = CNT_W'(T_MIN_GREEN - 1);
                if (at_least && (side_car || ped_pending)) state_nxt = MAIN_YELLOW;
            end
            MAIN_YELLOW: begin
                main_lights = YEL;
                thresh      = CNT_W'(T_YELLOW - 1);
                if (at_least) state_nxt = ALL_RED_A;
            end
            ALL_RED_A: begin
                thresh = CNT_W'(T_ALL_RED - 1);
                if (at_least) state_nxt = ped_pending ? PED_WALK : SIDE_GREEN;
            end
            PED_WALK: begin
                walk   = 1'b1;
                thresh = CNT_W'(T_WALK - 1);
                if (at_least) state_nxt = side_car ? SIDE_GREEN : ALL_RED_B;
            end
            SIDE_GREEN: begin
                side_lights = GRN;
                thresh      = CNT_W'(T_MIN_GREEN - 1);
                if (count == CNT_W'(T_MAX_SIDE - 1) || (at_least && !side_car)) state_nxt = SIDE_YELLOW;
            end
            SIDE_YELLOW: begin
                side_lights = YEL;
                thresh      = CNT_W'(T_YELLOW - 1);
                if (at_least) state_nxt = ALL_RED_B;
            end
            ALL_RED_B: begin
                thresh = CNT_W'(T_ALL_RED - 1);
                if (at_least) state_nxt = MAIN_GREEN;
            end
            default: state_nxt = MAIN_GREEN;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state       <= MAIN_GREEN;
            ped_pending <= 1'b0;
        end else begin
            state <= state_nxt;
            // walk requests are dropped; the pending flag retires when the walk phase ends
            if (state == PED_WALK) ped_pending <= (state_nxt == PED_WALK) ? ped_pending : 1'b0;
            else if (ped_req)      ped_pending <= 1'b1;
        end
    assign ped_ack = ped_pending;
endmodule
